// File: rtl/mem_stage_ctrl.sv
// M-stage memory controller: decodes load/store/write-back select, drives a req/ack data port
// through an IDLE/REQ/DONE wait-state FSM with timeout, and lane-aligns/extends data.
module mem_stage_ctrl #(
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 15,
    parameter int CNT_W    = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       ir_m,
    input  logic              valid_m,
    input  logic [31:0]       addr_m,
    input  logic [31:0]       wd_m,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic [31:0]       rd_data,
    output logic [1:0]        wd_sel,
    output logic              stall_m,
    output logic              exc_adel,
    output logic              exc_ades,
    output logic              timeout
);

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_WAIT - 1);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             we_q;
    logic [1:0]       size_q;
    logic             sx_q;
    logic [1:0]       lane_q;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic        is_load;
    logic        is_store;
    logic        sign_ext;
    logic [1:0]  size;
    logic        misaligned;
    logic        start;
    logic [3:0]  be_d;
    logic [31:0] wdata_d;
    logic        unused_ir;

    assign op        = ir_m[31:26];
    assign funct     = ir_m[5:0];
    assign unused_ir = ^ir_m[25:6];

    // Selects the addressed lane of the read word and extends it to 32 bits.
    function automatic logic [31:0] load_extend(input logic [1:0] sz, input logic sx,
                                                input logic [1:0] lane, input logic [31:0] word);
        logic [31:0] shifted;
        logic [15:0] half;
        logic [31:0] result;
        shifted = word >> {lane, 3'b000};
        half    = lane[1] ? word[31:16] : word[15:0];
        case (sz)
            SZ_B:    result = sx ? {{24{shifted[7]}}, shifted[7:0]} : {24'd0, shifted[7:0]};
            SZ_H:    result = sx ? {{16{half[15]}}, half} : {16'd0, half};
            default: result = word;
        endcase
        return result;
    endfunction

    always_comb begin
        is_load  = 1'b0;
        is_store = 1'b0;
        sign_ext = 1'b0;
        size     = SZ_W;
        wd_sel   = 2'd0;
        if (valid_m) begin
            case (op)
                6'h00: begin
                    case (funct)
                        6'h10, 6'h12: wd_sel = 2'd3;
                        6'h09:        wd_sel = 2'd2;
                        default:      wd_sel = 2'd0;
                    endcase
                end
                6'h03: wd_sel = 2'd2;
                6'h20: begin is_load = 1'b1; sign_ext = 1'b1; size = SZ_B; wd_sel = 2'd1; end
                6'h21: begin is_load = 1'b1; sign_ext = 1'b1; size = SZ_H; wd_sel = 2'd1; end
                6'h23: begin is_load = 1'b1; size = SZ_W; wd_sel = 2'd1; end
                6'h24: begin is_load = 1'b1; size = SZ_B; wd_sel = 2'd1; end
                6'h25: begin is_load = 1'b1; size = SZ_H; wd_sel = 2'd1; end
                6'h28: begin is_store = 1'b1; size = SZ_B; end
                6'h29: begin is_store = 1'b1; size = SZ_H; end
                6'h2B: begin is_store = 1'b1; size = SZ_W; end
                default: wd_sel = 2'd0;
            endcase
        end
    end

    assign misaligned = ((size == SZ_H) && addr_m[0]) ||
                        ((size == SZ_W) && (addr_m[1:0] != 2'b00));
    assign exc_adel   = is_load && misaligned;
    assign exc_ades   = is_store && misaligned;
    assign start      = (is_load || is_store) && !misaligned;

    always_comb begin
        case (size)
            SZ_B: begin
                be_d    = 4'b0001 << addr_m[1:0];
                wdata_d = {4{wd_m[7:0]}};
            end
            SZ_H: begin
                be_d    = addr_m[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{wd_m[15:0]}};
            end
            default: begin
                be_d    = 4'b1111;
                wdata_d = wd_m;
            end
        endcase
    end

    assign mem_req = (state == REQ);
    assign mem_we  = (state == REQ) && we_q;
    assign stall_m = (state == REQ) || ((state == IDLE) && start);
    assign timeout = (state == REQ) && !mem_ack && (cnt == LAST_CNT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            rd_data   <= '0;
            mem_addr  <= '0;
            mem_be    <= '0;
            mem_wdata <= '0;
            we_q      <= 1'b0;
            size_q    <= SZ_B;
            sx_q      <= 1'b0;
            lane_q    <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state     <= REQ;
                        cnt       <= '0;
                        mem_addr  <= {addr_m[ADDR_W-1:2], 2'b00};
                        mem_be    <= be_d;
                        mem_wdata <= wdata_d;
                        we_q      <= is_store;
                        size_q    <= size;
                        sx_q      <= sign_ext;
                        lane_q    <= addr_m[1:0];
                    end
                end
                REQ: begin
                    // An ack in the final wait cycle still counts as a normal completion.
                    if (mem_ack) begin
                        rd_data <= load_extend(size_q, sx_q, lane_q, mem_rdata);
                        state   <= DONE;
                    end else if (cnt == LAST_CNT) begin
                        rd_data <= '0;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: expected access results are queued at drive time
// and compared when the controller finishes the access.
module tb_mem_stage_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] ir_m;
    logic        valid_m;
    logic [31:0] addr_m;
    logic [31:0] wd_m;
    logic        mem_req;
    logic        mem_we;
    logic [3:0]  mem_be;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic [31:0] rd_data;
    logic [1:0]  wd_sel;
    logic        stall_m;
    logic        exc_adel;
    logic        exc_ades;
    logic        timeout;

    int total;
    int bad;

    typedef struct packed {
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] addr;
        logic [31:0] rd;
        logic        chk_rd;
        logic [1:0]  sel;
        logic [7:0]  stalls;
        logic [7:0]  to_cyc;
    } exp_t;

    exp_t sb[$];

    localparam logic [31:0] LW  = {6'h23, 26'd0};
    localparam logic [31:0] LB  = {6'h20, 26'd0};
    localparam logic [31:0] LBU = {6'h24, 26'd0};
    localparam logic [31:0] LH  = {6'h21, 26'd0};
    localparam logic [31:0] LHU = {6'h25, 26'd0};
    localparam logic [31:0] SB  = {6'h28, 26'd0};
    localparam logic [31:0] SH  = {6'h29, 26'd0};
    localparam logic [31:0] SW  = {6'h2B, 26'd0};

    mem_stage_ctrl #(.ADDR_W(32), .MAX_WAIT(15), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .ir_m(ir_m), .valid_m(valid_m), .addr_m(addr_m),
        .wd_m(wd_m), .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
        .mem_rdata(mem_rdata), .rd_data(rd_data), .wd_sel(wd_sel), .stall_m(stall_m),
        .exc_adel(exc_adel), .exc_ades(exc_ades), .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] be, input logic [31:0] wdata, input logic we,
                                input logic [31:0] addr, input logic [31:0] rd, input logic chk_rd,
                                input logic [1:0] sel, input int stalls, input int to_cyc);
        exp_t e;
        e.be = be; e.wdata = wdata; e.we = we; e.addr = addr; e.rd = rd;
        e.chk_rd = chk_rd; e.sel = sel; e.stalls = 8'(stalls); e.to_cyc = 8'(to_cyc);
        return e;
    endfunction

    // ack_at = REQ cycle (1-based) in which the ack is presented; 0 = never
    task automatic run_access(input string tag, input logic [31:0] ir, input logic [31:0] addr,
                              input logic [31:0] wd, input int ack_at, input logic [31:0] rdata,
                              input exp_t e);
        exp_t x;
        int   req_n;
        int   stalls;
        int   to_cyc;
        int   to_cnt;
        bit   done;
        sb.push_back(e);
        @(negedge clk);
        ir_m = ir; valid_m = 1'b1; addr_m = addr; wd_m = wd; mem_ack = 1'b0; mem_rdata = rdata;
        #1;
        stalls = stall_m ? 1 : 0;
        req_n = 0; to_cyc = 0; to_cnt = 0; done = 0;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (mem_req) begin
                req_n++;
                mem_ack = (req_n == ack_at);
                #1;
                if (req_n == 1) begin
                    chk_val({tag, ".be"}, {28'd0, mem_be}, {28'd0, sb[0].be});
                    chk_val({tag, ".addr"}, mem_addr, sb[0].addr);
                    chk_val({tag, ".we"}, {31'd0, mem_we}, {31'd0, sb[0].we});
                    if (sb[0].we) chk_val({tag, ".wdata"}, mem_wdata, sb[0].wdata);
                end
                if (stall_m) stalls++;
                if (timeout) begin to_cnt++; to_cyc = req_n; end
            end else begin
                mem_ack = 1'b0;
                #1;
                done = 1;
            end
        end
        x = sb.pop_front();
        if (!done) chk_val({tag, ".bound"}, 32'd0, 32'd1);
        chk_val({tag, ".stalls"}, 32'(stalls), 32'(x.stalls));
        chk_val({tag, ".to_cyc"}, 32'(to_cyc), 32'(x.to_cyc));
        chk_val({tag, ".to_cnt"}, 32'(to_cnt), (x.to_cyc != 0) ? 32'd1 : 32'd0);
        chk_val({tag, ".done_stall"}, {31'd0, stall_m}, 32'd0);
        chk_val({tag, ".wd_sel"}, {30'd0, wd_sel}, {30'd0, x.sel});
        if (x.chk_rd) chk_val({tag, ".rd"}, rd_data, x.rd);
        valid_m = 1'b0;
        @(negedge clk);
        #1;
        chk_val({tag, ".idle_req"}, {31'd0, mem_req}, 32'd0);
    endtask

    task automatic decode_case(input string tag, input logic [31:0] ir, input logic v,
                               input logic [31:0] addr, input logic [1:0] sel);
        @(negedge clk);
        ir_m = ir; valid_m = v; addr_m = addr;
        #1;
        chk_val({tag, ".sel"}, {30'd0, wd_sel}, {30'd0, sel});
        chk_val({tag, ".stall"}, {31'd0, stall_m}, 32'd0);
        chk_val({tag, ".exc"}, {30'd0, exc_adel, exc_ades}, 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; ir_m = '0; valid_m = 1'b0; addr_m = '0; wd_m = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        chk_val("rst.req", {31'd0, mem_req}, 32'd0);
        chk_val("rst.stall", {31'd0, stall_m}, 32'd0);
        chk_val("rst.rd", rd_data, 32'd0);
        chk_val("rst.to", {31'd0, timeout}, 32'd0);
        chk_val("rst.be", {28'd0, mem_be}, 32'd0);
        chk_val("rst.addr", mem_addr, 32'd0);

        run_access("lw", LW, 32'h100, 32'd0, 3, 32'hDEADBEEF,
                   mk(4'b1111, 32'd0, 1'b0, 32'h100, 32'hDEADBEEF, 1'b1, 2'd1, 4, 0));
        run_access("lb", LB, 32'h103, 32'd0, 1, 32'h80FFFF00,
                   mk(4'b1000, 32'd0, 1'b0, 32'h100, 32'hFFFFFF80, 1'b1, 2'd1, 2, 0));
        run_access("lbu", LBU, 32'h103, 32'd0, 1, 32'h80FFFF00,
                   mk(4'b1000, 32'd0, 1'b0, 32'h100, 32'h00000080, 1'b1, 2'd1, 2, 0));
        run_access("lh", LH, 32'h102, 32'd0, 2, 32'h80FFFF00,
                   mk(4'b1100, 32'd0, 1'b0, 32'h100, 32'hFFFF80FF, 1'b1, 2'd1, 3, 0));
        run_access("lhu", LHU, 32'h102, 32'd0, 2, 32'h80FFFF00,
                   mk(4'b1100, 32'd0, 1'b0, 32'h100, 32'h000080FF, 1'b1, 2'd1, 3, 0));
        run_access("sh", SH, 32'h102, 32'h1234ABCD, 1, 32'd0,
                   mk(4'b1100, 32'hABCDABCD, 1'b1, 32'h100, 32'd0, 1'b0, 2'd0, 2, 0));
        run_access("sb", SB, 32'h101, 32'h00000055, 1, 32'd0,
                   mk(4'b0010, 32'h55555555, 1'b1, 32'h100, 32'd0, 1'b0, 2'd0, 2, 0));
        run_access("sw", SW, 32'h200, 32'hCAFEF00D, 2, 32'd0,
                   mk(4'b1111, 32'hCAFEF00D, 1'b1, 32'h200, 32'd0, 1'b0, 2'd0, 3, 0));

        // misaligned accesses raise the exception without requesting or stalling
        @(negedge clk);
        ir_m = SH; valid_m = 1'b1; addr_m = 32'h101; wd_m = 32'h1234ABCD;
        #1;
        chk_val("sh_mis.ades", {31'd0, exc_ades}, 32'd1);
        chk_val("sh_mis.adel", {31'd0, exc_adel}, 32'd0);
        chk_val("sh_mis.stall", {31'd0, stall_m}, 32'd0);
        @(negedge clk);
        ir_m = LW; addr_m = 32'h102;
        #1;
        chk_val("sh_mis.req", {31'd0, mem_req}, 32'd0);
        chk_val("lw_mis.adel", {31'd0, exc_adel}, 32'd1);
        chk_val("lw_mis.stall", {31'd0, stall_m}, 32'd0);
        @(negedge clk);
        valid_m = 1'b0;
        #1;
        chk_val("lw_mis.req", {31'd0, mem_req}, 32'd0);

        // reset in the second REQ cycle; a late ack must not be captured
        @(negedge clk);
        ir_m = LW; valid_m = 1'b1; addr_m = 32'h100; mem_rdata = 32'h12345678;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk_val("rstmid.req_before", {31'd0, mem_req}, 32'd1);
        reset = 1'b1; valid_m = 1'b0;
        @(negedge clk);
        reset = 1'b0; mem_ack = 1'b1;
        #1;
        chk_val("rstmid.req", {31'd0, mem_req}, 32'd0);
        chk_val("rstmid.stall", {31'd0, stall_m}, 32'd0);
        chk_val("rstmid.rd", rd_data, 32'd0);
        @(negedge clk);
        mem_ack = 1'b0;
        #1;
        chk_val("rstmid.late_req", {31'd0, mem_req}, 32'd0);
        chk_val("rstmid.late_rd", rd_data, 32'd0);

        run_access("lw_pre", LW, 32'h104, 32'd0, 1, 32'hA5A5_0F0F,
                   mk(4'b1111, 32'd0, 1'b0, 32'h104, 32'hA5A50F0F, 1'b1, 2'd1, 2, 0));
        run_access("lw_to", LW, 32'h300, 32'd0, 0, 32'h11111111,
                   mk(4'b1111, 32'd0, 1'b0, 32'h300, 32'd0, 1'b1, 2'd1, 16, 15));
        run_access("lw_ack15", LW, 32'h304, 32'd0, 15, 32'h0BADF00D,
                   mk(4'b1111, 32'd0, 1'b0, 32'h304, 32'h0BADF00D, 1'b1, 2'd1, 16, 0));

        decode_case("jal", {6'h03, 26'd0}, 1'b1, 32'd0, 2'd2);
        decode_case("jalr", {6'h00, 20'd0, 6'h09}, 1'b1, 32'd0, 2'd2);
        decode_case("mfhi", {6'h00, 20'd0, 6'h10}, 1'b1, 32'd0, 2'd3);
        decode_case("mflo", {6'h00, 20'd0, 6'h12}, 1'b1, 32'd0, 2'd3);
        decode_case("addiu", {6'h09, 26'd0}, 1'b1, 32'd0, 2'd0);
        decode_case("jr", {6'h00, 20'd0, 6'h08}, 1'b1, 32'd0, 2'd0);
        decode_case("bubble", LW, 1'b0, 32'h102, 2'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
